// File: rtl/demux_pkg.sv
// Shared definitions for the three-way demux: default word width and sel encodings.
package demux_pkg;

  localparam int unsigned DATA_W = 136;

  localparam logic [1:0] SEL_CH1 = 2'd0;
  localparam logic [1:0] SEL_CH2 = 2'd1;
  localparam logic [1:0] SEL_CH3 = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/demux_fifo.sv
// DEPTH-entry circular FIFO with registered storage; head word is presented directly.
module demux_fifo #(
  parameter int unsigned DATA_W = 136,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Guard against misuse even though the top never pushes full or pops empty.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux.sv
// Three-way output router: steers each accepted word to a per-channel FIFO selected by sel,
// dropping and counting words with the illegal code.
module demux #(
  parameter int unsigned DATA_W = demux_pkg::DATA_W,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic [DATA_W-1:0] data_out_3,
  output logic              out_valid_1,
  output logic              out_valid_2,
  output logic              out_valid_3,
  input  logic              out_ready_1,
  input  logic              out_ready_2,
  input  logic              out_ready_3,
  output logic [CNT_W-1:0]  cnt_1,
  output logic [CNT_W-1:0]  cnt_2,
  output logic [CNT_W-1:0]  cnt_3,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              err
);

  import demux_pkg::*;

  logic [2:0]        push, pop, full, empty, valid, ready;
  logic [DATA_W-1:0] head [3];
  logic [CNT_W-1:0]  cnt_q [3];
  logic [CNT_W-1:0]  cnt_d [3];
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              err_q, err_d;
  logic              accept, drop;

  // Ready looks only at registered fullness, so a same-cycle pop never opens the input.
  always_comb begin
    in_ready = 1'b1;
    case (sel)
      SEL_CH1: in_ready = ~full[0];
      SEL_CH2: in_ready = ~full[1];
      SEL_CH3: in_ready = ~full[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept  = in_valid & in_ready;
  assign push[0] = accept & (sel == SEL_CH1);
  assign push[1] = accept & (sel == SEL_CH2);
  assign push[2] = accept & (sel == SEL_CH3);
  assign drop    = accept & (sel == SEL_BAD);

  assign ready = {out_ready_3, out_ready_2, out_ready_1};
  assign valid = ~empty;
  assign pop   = valid & ready;

  for (genvar k = 0; k < 3; k++) begin : g_ch
    demux_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (push[k]),
      .data_i  (data_in),
      .pop_i   (pop[k]),
      .data_o  (head[k]),
      .full_o  (full[k]),
      .empty_o (empty[k])
    );
  end

  always_comb begin
    for (int k = 0; k < 3; k++) cnt_d[k] = cnt_q[k] + CNT_W'(pop[k]);
    drop_cnt_d = drop_cnt_q + CNT_W'(drop);
    err_d      = drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  assign data_out_1  = head[0];
  assign data_out_2  = head[1];
  assign data_out_3  = head[2];
  assign out_valid_1 = valid[0];
  assign out_valid_2 = valid[1];
  assign out_valid_3 = valid[2];
  assign cnt_1       = cnt_q[0];
  assign cnt_2       = cnt_q[1];
  assign cnt_3       = cnt_q[2];
  assign drop_cnt    = drop_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_demux.sv
// Directed self-checking bench for demux: routing, stall, drop, wrap and mid-run reset.
module tb_demux;

  localparam int unsigned DW = 136;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [1:0]    sel;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out_1, data_out_2, data_out_3;
  logic          out_valid_1, out_valid_2, out_valid_3;
  logic          out_ready_1, out_ready_2, out_ready_3;
  logic [CW-1:0] cnt_1, cnt_2, cnt_3, drop_cnt;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [DW-1:0] D0 = 136'h0123456789abcdef0123456789abcdef;
  localparam logic [DW-1:0] D1 = 136'hfedcba9876543210fedcba9876543210;
  localparam logic [DW-1:0] D2 = {17{8'h0f}};
  localparam logic [DW-1:0] DA = {17{8'haa}};

  always #5 clk = ~clk;

  demux #(.DATA_W(DW), .DEPTH(2), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .data_in     (data_in),
    .data_out_1  (data_out_1),
    .data_out_2  (data_out_2),
    .data_out_3  (data_out_3),
    .out_valid_1 (out_valid_1),
    .out_valid_2 (out_valid_2),
    .out_valid_3 (out_valid_3),
    .out_ready_1 (out_ready_1),
    .out_ready_2 (out_ready_2),
    .out_ready_3 (out_ready_3),
    .cnt_1       (cnt_1),
    .cnt_2       (cnt_2),
    .cnt_3       (cnt_3),
    .drop_cnt    (drop_cnt),
    .err         (err)
  );

  // Drive inputs just after the falling edge; checks that follow see state from the last rise.
  task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = v;
    sel      = s;
    data_in  = d;
    #1;
  endtask

  function automatic logic [DW-1:0] wrap_word(input int i);
    logic [7:0] b;
    b = 8'(8'h30 + i);
    return {17{b}};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; sel = 2'd0; data_in = '0;
    out_ready_1 = 1'b1; out_ready_2 = 1'b1; out_ready_3 = 1'b1;
    #3;
    n_checks++;
    if ({out_valid_1, out_valid_2, out_valid_3, err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_valid_err got %b want 0000",
                         {out_valid_1, out_valid_2, out_valid_3, err});
    end
    n_checks++;
    if ({cnt_1, cnt_2, cnt_3, drop_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_counters got %h %h %h %h want 0", cnt_1, cnt_2, cnt_3,
                         drop_cnt);
    end
    n_checks++;
    if ({data_out_1, data_out_2, data_out_3} !== '0) begin
      n_fail++; $display("FAIL reset_data got nonzero head word want 0");
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_checks++;
    if ({out_valid_1, out_valid_2, out_valid_3, err} !== 4'b0) begin
      n_fail++; $display("FAIL idle_valid got %b want 0000",
                         {out_valid_1, out_valid_2, out_valid_3, err});
    end
  endtask

  task automatic test_route();
    drive(1'b1, 2'd0, D0);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL route1_ready got %b want 1", in_ready); end
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if ({out_valid_1, out_valid_2, out_valid_3} !== 3'b100 || data_out_1 !== D0) begin
      n_fail++; $display("FAIL route1_out got v=%b d=%h want v=100 d=%h",
                         {out_valid_1, out_valid_2, out_valid_3}, data_out_1, D0);
    end
    drive(1'b1, 2'd1, D1);
    n_checks++;
    if (cnt_1 !== 16'd1 || out_valid_1 !== 1'b0) begin
      n_fail++; $display("FAIL route1_cnt got cnt=%0d v=%b want cnt=1 v=0", cnt_1, out_valid_1);
    end
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if ({out_valid_1, out_valid_2, out_valid_3} !== 3'b010 || data_out_2 !== D1) begin
      n_fail++; $display("FAIL route2_out got v=%b d=%h want v=010 d=%h",
                         {out_valid_1, out_valid_2, out_valid_3}, data_out_2, D1);
    end
    drive(1'b1, 2'd2, D2);
    n_checks++;
    if (cnt_2 !== 16'd1) begin n_fail++; $display("FAIL route2_cnt got %0d want 1", cnt_2); end
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if ({out_valid_1, out_valid_2, out_valid_3} !== 3'b001 || data_out_3 !== D2) begin
      n_fail++; $display("FAIL route3_out got v=%b d=%h want v=001 d=%h",
                         {out_valid_1, out_valid_2, out_valid_3}, data_out_3, D2);
    end
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if (cnt_3 !== 16'd1 || out_valid_3 !== 1'b0) begin
      n_fail++; $display("FAIL route3_cnt got cnt=%0d v=%b want cnt=1 v=0", cnt_3, out_valid_3);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] wa, wb, wc, we;
    wa = {17{8'h11}}; wb = {17{8'h22}}; wc = {17{8'h33}}; we = {17{8'h44}};
    out_ready_1 = 1'b0;
    drive(1'b1, 2'd0, wa);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_w1_ready got %b want 1", in_ready); end
    drive(1'b1, 2'd0, wb);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_w2_ready got %b want 1", in_ready); end
    drive(1'b1, 2'd0, wc);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full_ready got %b want 0", in_ready); end
    drive(1'b1, 2'd1, we);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ch2_ready got %b want 1", in_ready); end
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if (out_valid_2 !== 1'b1 || data_out_2 !== we) begin
      n_fail++; $display("FAIL stall_ch2_out got v=%b d=%h want v=1 d=%h", out_valid_2,
                         data_out_2, we);
    end
    n_checks++;
    if (out_valid_1 !== 1'b1 || data_out_1 !== wa || cnt_1 !== 16'd1) begin
      n_fail++; $display("FAIL stall_ch1_hold got v=%b d=%h cnt=%0d want v=1 d=%h cnt=1",
                         out_valid_1, data_out_1, cnt_1, wa);
    end
    out_ready_1 = 1'b1;
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if (out_valid_1 !== 1'b1 || data_out_1 !== wb || cnt_1 !== 16'd2) begin
      n_fail++; $display("FAIL stall_ch1_second got v=%b d=%h cnt=%0d want v=1 d=%h cnt=2",
                         out_valid_1, data_out_1, cnt_1, wb);
    end
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if (out_valid_1 !== 1'b0 || cnt_1 !== 16'd3 || cnt_2 !== 16'd2) begin
      n_fail++; $display("FAIL stall_drain got v=%b cnt1=%0d cnt2=%0d want v=0 cnt1=3 cnt2=2",
                         out_valid_1, cnt_1, cnt_2);
    end
  endtask

  task automatic test_drop();
    drive(1'b1, 2'd3, DA);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready got %b want 1", in_ready); end
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if (err !== 1'b1 || drop_cnt !== 16'd1) begin
      n_fail++; $display("FAIL drop_err got err=%b drop=%0d want err=1 drop=1", err, drop_cnt);
    end
    n_checks++;
    if ({out_valid_1, out_valid_2, out_valid_3} !== 3'b000) begin
      n_fail++; $display("FAIL drop_no_valid got %b want 000",
                         {out_valid_1, out_valid_2, out_valid_3});
    end
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if (err !== 1'b0 || drop_cnt !== 16'd1) begin
      n_fail++; $display("FAIL drop_pulse got err=%b drop=%0d want err=0 drop=1", err, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_q [$];
    int idx = 0;
    out_ready_3 = 1'b0;
    for (int c = 0; c < 40 && (idx < 10 || exp_q.size() != 0); c++) begin
      @(negedge clk);
      if (c == 3) out_ready_3 = 1'b1;
      in_valid = (idx < 10);
      sel      = 2'd2;
      data_in  = wrap_word(idx);
      #1;
      n_checks++;
      if (out_valid_3 !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL b2b_valid c=%0d got %b want %b", c, out_valid_3,
                           exp_q.size() != 0);
      end
      n_checks++;
      if (in_ready !== (exp_q.size() < 2)) begin
        n_fail++; $display("FAIL b2b_ready c=%0d got %b want %b", c, in_ready, exp_q.size() < 2);
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        if (data_out_3 !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_data c=%0d got %h want %h", c, data_out_3, exp_q[0]);
        end
      end
      if (out_ready_3 && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        exp_q.push_back(wrap_word(idx));
        idx++;
      end
    end
    n_checks++;
    if (idx != 10 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_timeout got sent=%0d pending=%0d want sent=10 pending=0", idx,
                         exp_q.size());
    end
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if (cnt_3 !== 16'd11 || out_valid_3 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_cnt got cnt=%0d v=%b want cnt=11 v=0", cnt_3, out_valid_3);
    end
  endtask

  task automatic test_reset_mid();
    out_ready_2 = 1'b0;
    drive(1'b1, 2'd1, {17{8'h5a}});
    drive(1'b1, 2'd1, {17{8'ha5}});
    drive(1'b0, 2'd0, '0);
    n_checks++;
    if (out_valid_2 !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre got v=%b want 1", out_valid_2);
    end
    sel = 2'd1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_full got %b want 0", in_ready); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid_2 !== 1'b0 || {cnt_1, cnt_2, cnt_3, drop_cnt} !== '0) begin
      n_fail++; $display("FAIL rstmid_async got v=%b cnt=%h %h %h %h want v=0 cnt=0",
                         out_valid_2, cnt_1, cnt_2, cnt_3, drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd1, '0);
    n_checks++;
    if (out_valid_2 !== 1'b0 || data_out_2 !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_gone got v=%b d=%h rdy=%b want v=0 d=0 rdy=1",
                         out_valid_2, data_out_2, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_route();
    test_stall();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
